// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared defines for the multi-cycle divider: ALU codes, FSM states, iteration count
package div_unit_pkg;

    localparam logic [5:0] ALU_DIV    = 6'b011100;
    localparam logic [5:0] ALU_DIVU   = 6'b001100;
    localparam int         DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set; 0x80000000 maps to itself, which is the right magnitude.
    function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response bundle between Execute and the divider
interface div_unit_if;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        busy;
    logic [63:0] result;

    modport master (output start, signed_div, annul, a, b, input ready, busy, result);
    modport slave  (input start, signed_div, annul, a, b, output ready, busy, result);
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring radix-2 shift-subtract iteration on 32-bit magnitudes
module div_step (
    input  logic [31:0] rem_i,
    input  logic        dvd_bit_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic        q_bit_o
);
    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {rem_i, dvd_bit_i};
    assign diff    = shifted - {1'b0, dvs_i};
    // A borrow means the divisor did not fit: keep the shifted remainder (fits 32 bits since it is below the divisor).
    assign q_bit_o = ~diff[32];
    assign rem_o   = diff[32] ? shifted[31:0] : diff[31:0];
endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-cycle signed/unsigned divider with HI/LO result and annul support
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  dif
);
    localparam logic [4:0] LAST_CNT = 5'(DIV_CYCLES - 1);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [63:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic [31:0] step_rem;
    logic        step_q;
    logic [31:0] quo_next;

    // quo_q starts as the dividend magnitude and is shifted out MSB-first while quotient bits shift in.
    div_step u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (quo_q[31]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    assign quo_next = {quo_q[30:0], step_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (dif.start && !dif.annul) begin
                    negq_d = dif.signed_div & (dif.a[31] ^ dif.b[31]);
                    negr_d = dif.signed_div & dif.a[31];
                    quo_d  = cond_neg(dif.a, dif.signed_div & dif.a[31]);
                    dvs_d  = cond_neg(dif.b, dif.signed_div & dif.b[31]);
                    rem_d  = 32'd0;
                    cnt_d  = 5'd0;
                    if (dif.b == 32'd0) begin
                        state_d  = S_DONE;
                        result_d = {dif.a, 32'hFFFF_FFFF};
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = quo_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = S_DONE;
                    result_d = {cond_neg(step_rem, negr_q), cond_neg(quo_next, negq_q)};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (dif.annul) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= 64'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign dif.ready  = (state_q == S_DONE);
    assign dif.busy   = busy_q;
    assign dif.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized and directed checks of div_unit against a transaction-level model
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  alu = 6'd0;
    logic        annul = 1'b0;
    logic [31:0] a_r = 32'd0;
    logic [31:0] b_r = 32'd0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          chk_en = 1'b0;

    div_unit_if dif();
    assign dif.start      = (alu == ALU_DIV) || (alu == ALU_DIVU);
    assign dif.signed_div = (alu == ALU_DIV);
    assign dif.annul      = annul;
    assign dif.a          = a_r;
    assign dif.b          = b_r;

    div_unit dut (.clk(clk), .rst(rst), .dif(dif));

    always #5 clk = ~clk;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Arithmetic reference: {remainder, quotient}.
    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, bit sd);
        int sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sd) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a; sb = b;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    bit          m_busy = 1'b0, m_ready = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res = 64'd0, m_pend = 64'd0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 1'b0; m_ready = 1'b0; m_res = 64'd0; m_left = 0;
        end else if (annul) begin
            m_busy = 1'b0; m_ready = 1'b0; m_left = 0;
        end else if (m_ready) begin
            m_ready = 1'b0; m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1; m_res = m_pend;
            end
        end else if (dif.start) begin
            m_busy = 1'b1;
            m_pend = ref_div(a_r, b_r, dif.signed_div);
            if (b_r == 32'd0) begin
                m_ready = 1'b1; m_res = m_pend;
            end else begin
                m_left = DIV_CYCLES;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 64'(dif.ready), 64'(m_ready));
            check("busy", 64'(dif.busy), 64'(m_busy));
            check("result", dif.result, m_res);
        end
    end

    task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic [5:0] ctl,
                      input int exp_lat, input logic [63:0] exp_res);
        int lat = -1;
        logic [63:0] res = 64'd0;
        @(posedge clk); #1;
        a_r = av; b_r = bv; alu = ctl;
        for (int k = 0; k < 80 && lat < 0; k++) begin
            @(negedge clk);
            if (dif.ready) begin lat = k; res = dif.result; end
        end
        check("op_latency", 64'(lat), 64'(exp_lat));
        check("op_result", res, exp_res);
        @(posedge clk); #1;
        alu = 6'd0;
    endtask

    task automatic abort_run(input bit use_rst, input logic [63:0] exp_res);
        int pulses = 0;
        @(posedge clk); #1;
        a_r = 32'd50; b_r = 32'd3; alu = ALU_DIVU;
        @(posedge clk); #1;
        alu = 6'd0;
        repeat (9) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b0; else annul = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; annul = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(dif.busy), 64'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dif.ready) pulses++;
        end
        check("abort_no_ready", 64'(pulses), 64'd0);
        check("abort_result", dif.result, exp_res);
    endtask

    initial begin
        int t[$];
        logic [63:0] r[$];
        check("model_divu", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        check("model_div_neg", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("model_div_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
        check("model_div0", ref_div(32'h1234, 32'd0, 1'b0), {32'h1234, 32'hFFFF_FFFF});

        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_result", dif.result, 64'd0);
        check("reset_busy", 64'(dif.busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        op(32'd100, 32'd7, ALU_DIVU, 33, {32'd2, 32'd14});
        op(32'hFFFF_FFF9, 32'd2, ALU_DIV, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        op(32'h8000_0000, 32'hFFFF_FFFF, ALU_DIV, 33, {32'd0, 32'h8000_0000});
        op(32'h1234, 32'd0, ALU_DIVU, 1, {32'h1234, 32'hFFFF_FFFF});
        op(32'hFFFF_FFF0, 32'd0, ALU_DIV, 1, {32'hFFFF_FFF0, 32'hFFFF_FFFF});

        // Back-to-back with start held; operands change during RUN and must not be picked up.
        @(posedge clk); #1;
        a_r = 32'd10; b_r = 32'd3; alu = ALU_DIVU;
        @(posedge clk); #1;
        a_r = 32'd9; b_r = 32'd4;
        for (int k = 1; k < 120 && t.size() < 2; k++) begin
            @(negedge clk);
            if (dif.ready) begin t.push_back(k); r.push_back(dif.result); end
        end
        @(posedge clk); #1;
        alu = 6'd0;
        while (t.size() < 2) begin t.push_back(-1); r.push_back(64'hX); end
        check("b2b_first_cycle", 64'(t[0]), 64'd33);
        check("b2b_second_cycle", 64'(t[1]), 64'd67);
        check("b2b_first_result", r[0], {32'd1, 32'd3});
        check("b2b_second_result", r[1], {32'd1, 32'd2});

        op(32'd100, 32'd7, ALU_DIVU, 33, {32'd2, 32'd14});
        abort_run(1'b0, {32'd2, 32'd14});
        abort_run(1'b1, 64'd0);

        @(posedge clk); #1;
        a_r = 32'd5; b_r = 32'd1; alu = ALU_DIV; annul = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("start_annul_busy", 64'(dif.busy), 64'd0);
        end
        @(posedge clk); #1;
        alu = 6'd0; annul = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 3))
                0:       alu = 6'd0;
                1:       alu = 6'b100000;
                2:       alu = ALU_DIV;
                default: alu = ALU_DIVU;
            endcase
            case ($urandom_range(0, 7))
                0:       begin a_r = $urandom; b_r = 32'd0; end
                1:       begin a_r = $urandom; b_r = 32'hFFFF_FFFF; end
                2:       begin a_r = 32'h8000_0000; b_r = $urandom; end
                3:       begin a_r = $urandom; b_r = $urandom_range(1, 15); end
                4:       begin a_r = $urandom_range(0, 15); b_r = $urandom; end
                default: begin a_r = $urandom; b_r = $urandom; end
            endcase
            annul = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #1;
        alu = 6'd0; annul = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1);
    end
endmodule
